// File: rtl/cpu_boot_loader_pkg.sv
// Shared definitions for the cpu boot loader: command codes, FSM state
// encoding and word-packing constants.
package cpu_boot_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  // Index of the final byte of a word / header (2-bit byte index).
  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  localparam logic [7:0] CMD_LOAD_IMEM = 8'h01;
  localparam logic [7:0] CMD_LOAD_DMEM = 8'h02;
  localparam logic [7:0] CMD_RUN       = 8'h03;
  localparam logic [7:0] CMD_HALT      = 8'h04;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    RUN   = 3'd5
  } state_t;

  function automatic logic is_load_cmd(input logic [7:0] b);
    return (b == CMD_LOAD_IMEM) || (b == CMD_LOAD_DMEM);
  endfunction

endpackage

// File: rtl/cpu_boot_loader_byte_packer.sv
// Little-endian byte-to-word packer.
// Ports:
//   clk, arst_n  clock / async active-low reset
//   clear        synchronous clear of index and assembly register
//   take         a byte is accepted this cycle
//   byte_in      accepted byte
//   word         assembled word (complete while word_valid is high)
//   idx          index of the next byte slot (0..3)
//   word_valid   one-cycle pulse the cycle after the 4th byte is taken
module cpu_boot_loader_byte_packer
  import cpu_boot_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clear,
  input  logic              take,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic [1:0]        idx,
  output logic              word_valid
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      word       <= '0;
      idx        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        word <= '0;
        idx  <= '0;
      end else if (take) begin
        word[{idx, 3'b000} +: 8] <= byte_in;
        idx                      <= idx + 2'd1;  // wraps to 0 after the 4th byte
        word_valid               <= (idx == LAST_IDX);
      end
    end
  end

endmodule

// File: rtl/cpu_boot_loader.sv
// Byte-stream program loader feeding the cpu external memory ports.
// Command stream: 01 LOAD_IMEM / 02 LOAD_DMEM + header(count16, base16) +
// count little-endian words; 03 RUN; 04 HALT (only in RUN).
// Optional feature macro: CPU_BOOT_LOADER_CHECKSUM_EN adds a trailing
// checksum byte per load (CSUM state).
// Ports:
//   clk, arst_n                clock / async active-low reset
//   s_valid, s_data, s_ready   input byte stream (transfer on valid && ready)
//   imem_addr/wen/wdata        instruction memory write port (byte address)
//   dmem_addr/wen/wdata        data memory write port (byte address)
//   cpu_enable                 cpu run enable
//   busy                       loader is mid-command (not IDLE / RUN)
//   error                      sticky protocol error, cleared by a valid command
module cpu_boot_loader
  import cpu_boot_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] imem_addr,
  output logic              imem_wen,
  output logic [DATA_W-1:0] imem_wdata,
  output logic [DATA_W-1:0] dmem_addr,
  output logic              dmem_wen,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              cpu_enable,
  output logic              busy,
  output logic              error
);

`ifdef CPU_BOOT_LOADER_CHECKSUM_EN
  localparam state_t LOAD_END = CSUM;
`else
  localparam state_t LOAD_END = IDLE;
`endif

  state_t             state, state_nxt;
  logic               sel_dmem;      // 1: current load targets dmem
  logic [1:0]         hdr_idx;
  logic [CNT_W-1:0]   remaining;
  logic [5:0]         base_lo;       // base[7:2]; base[1:0] is forced to 00
  logic [DATA_W-1:0]  addr;
  logic [DATA_W-1:0]  imem_addr_h, imem_wdata_h, dmem_addr_h, dmem_wdata_h;
  logic               take;
  logic               cnt_zero;
  logic [DATA_W-1:0]  pk_word;
  logic [1:0]         pk_idx;
  logic               pk_word_valid;
`ifdef CPU_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  assign take     = s_valid && s_ready;
  assign cnt_zero = (remaining == '0);

  cpu_boot_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .arst_n     (arst_n),
    .clear      (state == IDLE),
    .take       (take && (state == DATA)),
    .byte_in    (s_data),
    .word       (pk_word),
    .idx        (pk_idx),
    .word_valid (pk_word_valid)
  );

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic. s_ready is high in every state that reads s_valid
  // here, so s_valid alone implies a handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (s_valid) begin
        if (is_load_cmd(s_data))   state_nxt = HDR;
        else if (s_data == CMD_RUN) state_nxt = RUN;
      end
      HDR:   if (s_valid && hdr_idx == LAST_IDX) state_nxt = cnt_zero ? LOAD_END : DATA;
      DATA:  if (s_valid && pk_idx == LAST_IDX) state_nxt = WRITE;
      WRITE: state_nxt = (remaining == CNT_W'(1)) ? LOAD_END : DATA;
      CSUM:  if (s_valid) state_nxt = IDLE;
      RUN:   if (s_valid && s_data == CMD_HALT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. Write ports show the live address/word only during the write
  // cycle and otherwise hold what was last written.
  always_comb begin
    s_ready    = (state != WRITE);
    imem_wen   = (state == WRITE) && pk_word_valid && !sel_dmem;
    dmem_wen   = (state == WRITE) && pk_word_valid &&  sel_dmem;
    imem_addr  = imem_wen ? addr    : imem_addr_h;
    imem_wdata = imem_wen ? pk_word : imem_wdata_h;
    dmem_addr  = dmem_wen ? addr    : dmem_addr_h;
    dmem_wdata = dmem_wen ? pk_word : dmem_wdata_h;
    cpu_enable = (state == RUN);
    busy       = (state != IDLE) && (state != RUN);
  end

  // Datapath: header decode, address/count tracking, error flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sel_dmem     <= 1'b0;
      hdr_idx      <= '0;
      remaining    <= '0;
      base_lo      <= '0;
      addr         <= '0;
      error        <= 1'b0;
      imem_addr_h  <= '0;
      imem_wdata_h <= '0;
      dmem_addr_h  <= '0;
      dmem_wdata_h <= '0;
    end else begin
      unique case (state)
        IDLE: if (take) begin
          if (is_load_cmd(s_data)) begin
            sel_dmem <= (s_data == CMD_LOAD_DMEM);
            hdr_idx  <= '0;
            error    <= 1'b0;
          end else if (s_data == CMD_RUN) begin
            error    <= 1'b0;
          end else begin
            error    <= 1'b1;
          end
        end
        HDR: if (take) begin
          hdr_idx <= hdr_idx + 2'd1;
          case (hdr_idx)
            2'd0: remaining[7:0]  <= s_data;
            2'd1: remaining[15:8] <= s_data;
            2'd2: base_lo         <= s_data[7:2];
            default: addr         <= DATA_W'({s_data, base_lo, 2'b00});
          endcase
        end
        WRITE: begin
          addr      <= addr + DATA_W'(BYTES_PER_WORD);
          remaining <= remaining - CNT_W'(1);
          if (sel_dmem) begin
            dmem_addr_h  <= addr;
            dmem_wdata_h <= pk_word;
          end else begin
            imem_addr_h  <= addr;
            imem_wdata_h <= pk_word;
          end
        end
        RUN: if (take) error <= (s_data != CMD_HALT);
`ifdef CPU_BOOT_LOADER_CHECKSUM_EN
        CSUM: if (take && s_data != csum) error <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef CPU_BOOT_LOADER_CHECKSUM_EN
  // Running sum seeded with the command byte itself, so a zero-length
  // LOAD_IMEM (01 00 00 00 00) expects checksum 0x01.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      csum <= '0;
    end else if (take) begin
      if (state == IDLE)                      csum <= s_data;
      else if (state == HDR || state == DATA) csum <= csum + s_data;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_boot_loader.sv
module tb_cpu_boot_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, imem_wen, dmem_wen, cpu_enable, busy, error;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$];

  cpu_boot_loader #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .arst_n(arst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
    .cpu_enable(cpu_enable), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Log every write; s_ready must be low whenever a write is issued, and
  // no memory write may happen while the cpu is enabled.
  always @(negedge clk) begin
    if (imem_wen) begin iw_a.push_back(imem_addr); iw_d.push_back(imem_wdata); end
    if (dmem_wen) begin dw_a.push_back(dmem_addr); dw_d.push_back(dmem_wdata); end
    if (imem_wen || dmem_wen) begin
      vectors++;
      if (s_ready !== 1'b0 || (imem_wen && dmem_wen) || cpu_enable !== 1'b0) begin
        miscompares++;
        $display("FAIL write_cycle s_ready=%b imem_wen=%b dmem_wen=%b cpu_enable=%b, expected 0/one-hot/0",
                 s_ready, imem_wen, dmem_wen, cpu_enable);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit keep);
    int n;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    if (!s_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout byte=%h s_ready=%b, expected 1 within 50 cycles", b, s_ready);
    end else begin
      @(posedge clk);
    end
    if (!keep) begin #1; s_valid = 1'b0; end
  endtask

  task automatic clear_logs();
    iw_a.delete(); iw_d.delete(); dw_a.delete(); dw_d.delete();
  endtask

  task automatic test_reset();
    arst_n = 1'b0; s_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({s_ready, imem_wen, dmem_wen, cpu_enable, busy, error} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b expected=100000", {s_ready, imem_wen, dmem_wen, cpu_enable, busy, error});
    end
    vectors++;
    if ((imem_addr | imem_wdata | dmem_addr | dmem_wdata) !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_bus ia=%h id=%h da=%h dd=%h expected all 0", imem_addr, imem_wdata, dmem_addr, dmem_wdata);
    end
    arst_n = 1'b1;
  endtask

  // Two-word imem load with s_valid held high throughout (back-pressure).
  task automatic test_back_to_back();
    logic [7:0]  hdr[5]  = '{8'h01, 8'h02, 8'h00, 8'h10, 8'h00};
    logic [7:0]  dat[8]  = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [31:0] ea[2]   = '{32'h10, 32'h14};
    logic [31:0] ed[2]   = '{32'h12345678, 32'hDEADBEEF};
    clear_logs();
    foreach (hdr[i]) send(hdr[i], 1'b1);
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 4; b++) send(dat[w*4+b], 1'b1);
      @(negedge clk);  // WRITE cycle: one after the 4th handshake
      vectors++;
      if (imem_wen !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1 || dmem_wen !== 1'b0) begin
        miscompares++;
        $display("FAIL imem_write_cycle%0d wen=%b ready=%b busy=%b dwen=%b expected 1 0 1 0", w, imem_wen, s_ready, busy, dmem_wen);
      end
      vectors++;
      if (imem_addr !== ea[w] || imem_wdata !== ed[w]) begin
        miscompares++;
        $display("FAIL imem_word%0d got %h/%h expected %h/%h", w, imem_addr, imem_wdata, ea[w], ed[w]);
      end
    end
`ifdef CPU_BOOT_LOADER_CHECKSUM_EN
    send(8'h5F, 1'b0);
`else
    s_valid = 1'b0;
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if (iw_a.size() != 2 || dw_a.size() != 0) begin
      miscompares++;
      $display("FAIL imem_write_count imem=%0d dmem=%0d expected 2 0", iw_a.size(), dw_a.size());
    end else begin
      vectors++;
      if (iw_a[0] !== 32'h10 || iw_d[0] !== 32'h12345678 || iw_a[1] !== 32'h14 || iw_d[1] !== 32'hDEADBEEF) begin
        miscompares++;
        $display("FAIL imem_log %h/%h %h/%h", iw_a[0], iw_d[0], iw_a[1], iw_d[1]);
      end
    end
    vectors++;
    if (busy !== 1'b0 || error !== 1'b0 || imem_wen !== 1'b0 || imem_addr !== 32'h14 || imem_wdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL imem_after busy=%b err=%b wen=%b addr=%h data=%h expected 0 0 0 14 deadbeef",
               busy, error, imem_wen, imem_addr, imem_wdata);
    end
  endtask

  task automatic test_load_dmem();
    logic [7:0] bytes[9] = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
    clear_logs();
    foreach (bytes[i]) send(bytes[i], (i != 8));
`ifdef CPU_BOOT_LOADER_CHECKSUM_EN
    send(8'hAB, 1'b0);
`endif
    repeat (3) @(negedge clk);
    vectors++;
    if (dw_a.size() != 1 || iw_a.size() != 0) begin
      miscompares++;
      $display("FAIL dmem_write_count dmem=%0d imem=%0d expected 1 0", dw_a.size(), iw_a.size());
    end else begin
      vectors++;
      if (dw_a[0] !== 32'h0000FFFC || dw_d[0] !== 32'h44332211) begin
        miscompares++;
        $display("FAIL dmem_word got %h/%h expected 0000fffc/44332211", dw_a[0], dw_d[0]);
      end
    end
    vectors++;
    if (imem_addr !== 32'h14 || dmem_addr !== 32'hFFFC || error !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL dmem_after ia=%h da=%h err=%b busy=%b expected 14 fffc 0 0", imem_addr, dmem_addr, error, busy);
    end
  endtask

  task automatic test_bad_cmd();
    send(8'h09, 1'b0);
    @(negedge clk);
    vectors++;
    if (error !== 1'b1 || busy !== 1'b0 || cpu_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_cmd err=%b busy=%b en=%b expected 1 0 0", error, busy, cpu_enable);
    end
  endtask

  task automatic test_run_halt();
    send(8'h03, 1'b0);
    @(negedge clk);
    vectors++;
    if (cpu_enable !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL run en=%b err=%b busy=%b expected 1 0 0", cpu_enable, error, busy);
    end
    send(8'h05, 1'b0);
    @(negedge clk);
    vectors++;
    if (cpu_enable !== 1'b1 || error !== 1'b1) begin
      miscompares++;
      $display("FAIL run_bad en=%b err=%b expected 1 1", cpu_enable, error);
    end
    send(8'h01, 1'b0);  // load command is not decoded in RUN
    @(negedge clk);
    vectors++;
    if (cpu_enable !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL run_load_ignored en=%b busy=%b expected 1 0", cpu_enable, busy);
    end
    send(8'h04, 1'b0);
    @(negedge clk);
    vectors++;
    if (cpu_enable !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL halt en=%b busy=%b expected 0 0", cpu_enable, busy);
    end
    send(8'h04, 1'b0);  // HALT outside RUN is not a valid command
    @(negedge clk);
    vectors++;
    if (error !== 1'b1 || cpu_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_in_idle err=%b en=%b expected 1 0", error, cpu_enable);
    end
  endtask

  // Zero-count load also clears the error left by the previous test.
  task automatic test_count_zero();
    logic [7:0] bytes[5] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_logs();
    foreach (bytes[i]) send(bytes[i], (i != 4));
    @(negedge clk);
`ifdef CPU_BOOT_LOADER_CHECKSUM_EN
    vectors++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL csum_wait busy=%b err=%b expected 1 0", busy, error);
    end
    send(8'h01, 1'b0);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL csum_good busy=%b err=%b expected 0 0", busy, error);
    end
    foreach (bytes[i]) send(bytes[i], (i != 4));
    send(8'h02, 1'b0);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || error !== 1'b1) begin
      miscompares++;
      $display("FAIL csum_bad busy=%b err=%b expected 0 1", busy, error);
    end
`else
    vectors++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL count_zero busy=%b err=%b expected 0 0", busy, error);
    end
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if (iw_a.size() != 0 || dw_a.size() != 0) begin
      miscompares++;
      $display("FAIL count_zero_writes imem=%0d dmem=%0d expected 0 0", iw_a.size(), dw_a.size());
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] bytes[8] = '{8'h01, 8'h01, 8'h00, 8'h20, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    clear_logs();
    foreach (bytes[i]) send(bytes[i], 1'b1);
    @(negedge clk);  // 4th data byte pending on the bus
    arst_n = 1'b0; s_valid = 1'b0;
    #1;
    vectors++;
    if ({s_ready, imem_wen, dmem_wen, cpu_enable, busy, error} !== 6'b100000 || imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midload_reset ctrl=%b ia=%h id=%h expected 100000 0 0",
               {s_ready, imem_wen, dmem_wen, cpu_enable, busy, error}, imem_addr, imem_wdata);
    end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (iw_a.size() != 0 || dw_a.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_no_write imem=%0d dmem=%0d busy=%b expected 0 0 0", iw_a.size(), dw_a.size(), busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_load_dmem();
    test_bad_cmd();
    test_run_halt();
    test_count_zero();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
